// File: rtl/pipe_elastic_stage_pkg.sv
// Shared pipeline definitions: elastic stage state encoding and
// per-stage control bundles with their NOP encodings.
package pipe_definitions;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_HALF  = 2'd1,
        PS_FULL  = 2'd2
    } pipe_state_t;

    typedef struct packed {
        logic       br_none;
        logic       pc_inc;
        logic [5:0] rsvd;
    } if_id_ctrl_t;

    localparam if_id_ctrl_t IF_ID_NOP = '{
        br_none: 1'b1,
        pc_inc:  1'b1,
        rsvd:    6'd0
    };

    typedef struct packed {
        logic [4:0] rd;
        logic       reg_write;
        logic       mem_write;
        logic       mem_read;
        logic [3:0] alu_op;
        logic [3:0] br_op;
    } id_ex_ctrl_t;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] BR_NONE = 4'd0;

    localparam id_ex_ctrl_t ID_EX_NOP = '{
        rd:        5'd0,
        reg_write: 1'b0,
        mem_write: 1'b0,
        mem_read:  1'b0,
        alu_op:    ALU_ADD,
        br_op:     BR_NONE
    };

    // Entry count held in a given state.
    function automatic logic [1:0] pipe_occ(pipe_state_t s);
        unique case (s)
            PS_HALF: pipe_occ = 2'd1;
            PS_FULL: pipe_occ = 2'd2;
            default: pipe_occ = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_elastic_stage.sv
// Elastic pipeline register with valid/ready handshake and optional
// 2-entry skid buffer (registered in_ready).
//
// Ports: clk, rst (async, active-high), flush (sync kill),
//   in_valid/in_ready/in_ctrl/in_data   upstream beat,
//   out_valid/out_ready/out_ctrl/out_data downstream beat (head entry),
//   occupancy  number of held entries (0..2).
module pipe_elastic_stage
    import pipe_definitions::*;
#(
    parameter int unsigned       CTRL_W   = 16,
    parameter int unsigned       DATA_W   = 128,
    parameter logic [CTRL_W-1:0] CTRL_RST = '0,
    parameter int unsigned       SKID     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    pipe_state_t state_q;
    pipe_state_t state_d;

    logic [CTRL_W-1:0] head_ctrl;
    logic [DATA_W-1:0] head_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    logic in_xfer;
    logic out_xfer;
    logic head_ld_in;
    logic head_ld_skid;
    logic skid_ld;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= PS_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = PS_EMPTY;
        end else begin
            unique case (state_q)
                PS_EMPTY: begin
                    if (in_xfer) state_d = PS_HALF;
                end
                PS_HALF: begin
                    if (in_xfer && !out_xfer) begin
                        state_d = (SKID != 0) ? PS_FULL : PS_HALF;
                    end else if (!in_xfer && out_xfer) begin
                        state_d = PS_EMPTY;
                    end
                end
                PS_FULL: begin
                    if (out_xfer) state_d = PS_HALF;
                end
                default: state_d = PS_EMPTY;
            endcase
        end
    end

    always_comb begin
        out_valid = (state_q != PS_EMPTY);
        occupancy = pipe_occ(state_q);
    end

    // Skid mode decodes ready from state only, cutting the
    // out_ready -> in_ready path between stages.
    generate
        if (SKID != 0) begin : g_skid
            assign in_ready = (state_q != PS_FULL);
        end else begin : g_single
            assign in_ready = !out_valid | out_ready;
        end
    endgenerate

    assign head_ld_in = !flush && in_xfer &&
        ((state_q == PS_EMPTY) ||
         ((state_q == PS_HALF) && out_xfer));

    assign head_ld_skid = !flush && out_xfer &&
        (state_q == PS_FULL);

    assign skid_ld = !flush && (SKID != 0) && in_xfer &&
        !out_xfer && (state_q == PS_HALF);

    // Flush forces control to the NOP encoding but leaves data as is.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_ctrl <= CTRL_RST;
            head_data <= '0;
            skid_ctrl <= CTRL_RST;
            skid_data <= '0;
        end else if (flush) begin
            head_ctrl <= CTRL_RST;
            skid_ctrl <= CTRL_RST;
        end else begin
            if (head_ld_in) begin
                head_ctrl <= in_ctrl;
                head_data <= in_data;
            end else if (head_ld_skid) begin
                head_ctrl <= skid_ctrl;
                head_data <= skid_data;
            end
            if (skid_ld) begin
                skid_ctrl <= in_ctrl;
                skid_data <= in_data;
            end
        end
    end

    assign out_ctrl = head_ctrl;
    assign out_data = head_data;

endmodule

// File: tb/tb_pipe_elastic_stage.sv
// Directed bench for pipe_elastic_stage: one SKID=1 and one SKID=0
// instance, CTRL_W=8, DATA_W=32, CTRL_RST=8'hA5.
module tb_pipe_elastic_stage;

    logic clk;
    logic rst;

    logic       a_flush, a_in_valid, a_in_ready;
    logic [7:0] a_in_ctrl, a_out_ctrl;
    logic [31:0] a_in_data, a_out_data;
    logic       a_out_valid, a_out_ready;
    logic [1:0] a_occ;

    logic       b_flush, b_in_valid, b_in_ready;
    logic [7:0] b_in_ctrl, b_out_ctrl;
    logic [31:0] b_in_data, b_out_data;
    logic       b_out_valid, b_out_ready;
    logic [1:0] b_occ;

    int checks = 0;
    int errors = 0;

    pipe_elastic_stage #(
        .CTRL_W(8), .DATA_W(32), .CTRL_RST(8'hA5), .SKID(1)
    ) u_skid (
        .clk(clk), .rst(rst), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_ctrl(a_in_ctrl), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_ctrl(a_out_ctrl), .out_data(a_out_data),
        .occupancy(a_occ)
    );

    pipe_elastic_stage #(
        .CTRL_W(8), .DATA_W(32), .CTRL_RST(8'hA5), .SKID(0)
    ) u_single (
        .clk(clk), .rst(rst), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_ctrl(b_in_ctrl), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_ctrl(b_out_ctrl), .out_data(b_out_data),
        .occupancy(b_occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        a_flush = 0; a_in_valid = 0; a_in_ctrl = 0; a_in_data = 0;
        a_out_ready = 0;
        b_flush = 0; b_in_valid = 0; b_in_ctrl = 0; b_in_data = 0;
        b_out_ready = 0;
        #12;
        rst = 1'b0;
        #1;
        chk("rst_a_valid", 32'(a_out_valid), 32'd0);
        chk("rst_a_ready", 32'(a_in_ready), 32'd1);
        chk("rst_a_ctrl", 32'(a_out_ctrl), 32'hA5);
        chk("rst_a_occ", 32'(a_occ), 32'd0);
        chk("rst_b_ready", 32'(b_in_ready), 32'd1);
        chk("rst_b_ctrl", 32'(b_out_ctrl), 32'hA5);
        step();

        // Fill the skid instance, then reset asynchronously mid-cycle.
        a_in_valid = 1; a_in_ctrl = 8'h01; a_in_data = 32'h11;
        a_out_ready = 0;
        step();
        a_in_ctrl = 8'h02; a_in_data = 32'h22;
        step();
        chk("full_occ", 32'(a_occ), 32'd2);
        chk("full_ready", 32'(a_in_ready), 32'd0);
        chk("full_head", a_out_data, 32'h11);
        a_in_valid = 0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(a_out_valid), 32'd0);
        chk("arst_ready", 32'(a_in_ready), 32'd1);
        chk("arst_ctrl", 32'(a_out_ctrl), 32'hA5);
        chk("arst_data", a_out_data, 32'h0);
        chk("arst_occ", 32'(a_occ), 32'd0);
        rst = 1'b0;
        step();

        // Back-to-back streaming through both instances.
        a_out_ready = 1; b_out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            a_in_valid = 1; a_in_ctrl = 8'(i + 1);
            a_in_data = 32'h10 + 32'(i);
            b_in_valid = 1; b_in_ctrl = 8'(i + 1);
            b_in_data = 32'h10 + 32'(i);
            step();
            chk("str_a_valid", 32'(a_out_valid), 32'd1);
            chk("str_a_ctrl", 32'(a_out_ctrl), 32'(i + 1));
            chk("str_a_data", a_out_data, 32'h10 + 32'(i));
            chk("str_a_occ", 32'(a_occ), 32'd1);
            chk("str_a_ready", 32'(a_in_ready), 32'd1);
            chk("str_b_valid", 32'(b_out_valid), 32'd1);
            chk("str_b_ctrl", 32'(b_out_ctrl), 32'(i + 1));
            chk("str_b_data", b_out_data, 32'h10 + 32'(i));
            chk("str_b_occ", 32'(b_occ), 32'd1);
        end
        a_in_valid = 0; b_in_valid = 0;
        step();
        chk("str_a_drain", 32'(a_out_valid), 32'd0);
        chk("str_b_drain", 32'(b_out_valid), 32'd0);

        // Skid backpressure: one extra beat absorbed, then drained in order.
        a_in_valid = 1; a_in_ctrl = 8'h0A; a_in_data = 32'hA0;
        step();
        a_out_ready = 0;
        a_in_ctrl = 8'h0B; a_in_data = 32'hB0;
        step();
        chk("bp_occ", 32'(a_occ), 32'd2);
        chk("bp_ready", 32'(a_in_ready), 32'd0);
        chk("bp_head", a_out_data, 32'hA0);
        a_in_ctrl = 8'h0C; a_in_data = 32'hC0;
        step();
        chk("bp_hold_occ", 32'(a_occ), 32'd2);
        chk("bp_hold_head", a_out_data, 32'hA0);
        a_out_ready = 1;
        step();
        chk("bp_d1_data", a_out_data, 32'hB0);
        chk("bp_d1_ctrl", 32'(a_out_ctrl), 32'h0B);
        chk("bp_d1_occ", 32'(a_occ), 32'd1);
        chk("bp_d1_ready", 32'(a_in_ready), 32'd1);
        step();
        chk("bp_d2_data", a_out_data, 32'hC0);
        chk("bp_d2_valid", 32'(a_out_valid), 32'd1);
        a_in_valid = 0;
        step();
        chk("bp_empty", 32'(a_out_valid), 32'd0);

        // Flush in FULL with a beat offered at the input.
        a_out_ready = 0;
        a_in_valid = 1; a_in_ctrl = 8'h0A; a_in_data = 32'hA0;
        step();
        a_in_ctrl = 8'h0B; a_in_data = 32'hB0;
        step();
        chk("fl_full_occ", 32'(a_occ), 32'd2);
        a_in_ctrl = 8'hEE; a_in_data = 32'hEE;
        a_flush = 1;
        step();
        a_flush = 0; a_in_valid = 0;
        chk("fl_valid", 32'(a_out_valid), 32'd0);
        chk("fl_ctrl", 32'(a_out_ctrl), 32'hA5);
        chk("fl_data", a_out_data, 32'hA0);
        chk("fl_occ", 32'(a_occ), 32'd0);
        chk("fl_ready", 32'(a_in_ready), 32'd1);
        a_out_ready = 1;
        step();
        chk("fl_no_ee", 32'(a_out_valid), 32'd0);

        // Skid register must hold the NOP after flush: refill and drain.
        a_out_ready = 0;
        a_in_valid = 1; a_in_ctrl = 8'h31; a_in_data = 32'h31;
        step();
        a_in_ctrl = 8'h32; a_in_data = 32'h32;
        step();
        a_in_valid = 0; a_out_ready = 1;
        step();
        chk("refill_ctrl", 32'(a_out_ctrl), 32'h32);
        chk("refill_data", a_out_data, 32'h32);
        step();
        chk("refill_empty", 32'(a_out_valid), 32'd0);

        // SKID=0: combinational ready follows out_ready.
        b_out_ready = 0;
        b_in_valid = 1; b_in_ctrl = 8'h03; b_in_data = 32'h33;
        step();
        b_in_ctrl = 8'h04; b_in_data = 32'h44;
        #1;
        chk("c_ready_lo", 32'(b_in_ready), 32'd0);
        step();
        chk("c_hold_data", b_out_data, 32'h33);
        chk("c_hold_occ", 32'(b_occ), 32'd1);
        b_out_ready = 1;
        b_in_ctrl = 8'h05; b_in_data = 32'h55;
        #1;
        chk("c_ready_hi", 32'(b_in_ready), 32'd1);
        step();
        chk("c_repl_data", b_out_data, 32'h55);
        chk("c_repl_ctrl", 32'(b_out_ctrl), 32'h05);
        chk("c_repl_occ", 32'(b_occ), 32'd1);

        // Flush together with an output handshake in HALF.
        b_in_ctrl = 8'h07; b_in_data = 32'h77;
        step();
        b_in_valid = 0; b_flush = 1;
        #1;
        chk("fh_deliver_v", 32'(b_out_valid), 32'd1);
        chk("fh_deliver_d", b_out_data, 32'h77);
        step();
        b_flush = 0;
        chk("fh_valid", 32'(b_out_valid), 32'd0);
        chk("fh_ctrl", 32'(b_out_ctrl), 32'hA5);
        chk("fh_occ", 32'(b_occ), 32'd0);

        // Flush in EMPTY keeps state empty and ctrl at NOP.
        a_flush = 1;
        step();
        a_flush = 0;
        chk("fe_valid", 32'(a_out_valid), 32'd0);
        chk("fe_ctrl", 32'(a_out_ctrl), 32'hA5);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
